dmul_rot_lfsr_param: RTL

Parametrised, handshaked successor to the fixed-8-bit rotating-LFSR stochastic multiplier. Two on-chip maximal-length LFSRs generate the A and B bitstreams. The B generator advances once per full A period, so a full-length run enumerates every (rA, rB) pair and returns the exact product count. Adds selectable unipolar/bipolar mode, programmable run length, and a start/busy/done handshake so the block can be sequenced by the SC-unit controllers.

---
 rtl/dmul_rot_lfsr_param.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/dmul_rot_lfsr_param.sv
// Rotating-LFSR stochastic multiplier with start/busy/done handshake.
// The A generator steps every compare cycle. The B generator steps once per
// full A period. A full-length run therefore visits every (rA, rB) pair exactly
// once and returns the exact product count.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for i_start; o_count holds the last result
// RUN    | one compare per cycle until the down-counter reaches zero
// DONE   | one-cycle o_done pulse; i_start here starts the next run
module dmul_rot_lfsr_param #(
   parameter int W  = 8,
   parameter int CW = 2 * W
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_start,
   input  logic [W-1:0]  i_a,
   input  logic [W-1:0]  i_b,
   input  logic [W-1:0]  i_seed_a,
   input  logic [W-1:0]  i_seed_b,
   input  logic          i_bipolar,
   input  logic [CW-1:0] i_len,
   output logic          o_busy,
   output logic          o_done,
   output logic [CW-1:0] o_count
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Maximal-length feedback masks for a shift-left Fibonacci LFSR, indexed by W.
   localparam logic [15:0] TAPS16 =
      (W == 4)  ? 16'h000C :
      (W == 5)  ? 16'h0014 :
      (W == 6)  ? 16'h0030 :
      (W == 7)  ? 16'h0060 :
      (W == 8)  ? 16'h00B8 :
      (W == 9)  ? 16'h0110 :
      (W == 10) ? 16'h0240 :
      (W == 11) ? 16'h0500 :
      (W == 12) ? 16'h0829 :
      (W == 13) ? 16'h100D :
      (W == 14) ? 16'h2015 :
      (W == 15) ? 16'h6000 :
                  16'hD008;
   localparam logic [W-1:0] TAP_MASK = TAPS16[W-1:0];

   // A full run is P*P compare cycles, where P = 2^W-1. That value always fits in CW bits.
   localparam longint unsigned P_L    = (longint'(1) << W) - longint'(1);
   localparam logic [CW-1:0]   FULL_N = CW'(P_L * P_L);
   localparam logic [W-1:0]    ONE_W  = {{(W-1){1'b0}}, 1'b1};

   function automatic logic [W-1:0] lfsr_next(input logic [W-1:0] s);
      return {s[W-2:0], ^(s & TAP_MASK)};
   endfunction

   state_t        state_q, state_d;
   logic [W-1:0]  a_q, a_d;
   logic [W-1:0]  b_q, b_d;
   logic [W-1:0]  seed_a_q, seed_a_d;
   logic          bip_q, bip_d;
   logic [CW-1:0] rem_q, rem_d;
   logic [W-1:0]  ra_q, ra_d;
   logic [W-1:0]  rb_q, rb_d;
   logic [CW-1:0] count_q, count_d;

   logic [W-1:0]  seed_a_in, seed_b_in, ra_nxt, rb_nxt;
   logic          sa, sb, prod_bit, accept;

   // Next-state, datapath and handshake decode.
   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      seed_a_d = seed_a_q;
      bip_d    = bip_q;
      rem_d    = rem_q;
      ra_d     = ra_q;
      rb_d     = rb_q;
      count_d  = count_q;

      // A zero seed would lock the LFSR at zero, so it is replaced by 1.
      seed_a_in = (i_seed_a == '0) ? ONE_W : i_seed_a;
      seed_b_in = (i_seed_b == '0) ? ONE_W : i_seed_b;
      ra_nxt    = lfsr_next(ra_q);
      rb_nxt    = lfsr_next(rb_q);
      sa        = (a_q >= ra_q);
      sb        = (b_q >= rb_q);
      prod_bit  = bip_q ? ~(sa ^ sb) : (sa & sb);
      accept    = i_start && (state_q != S_RUN);

      case (state_q)
         S_IDLE, S_DONE: begin
            if (accept) begin
               a_d      = i_a;
               b_d      = i_b;
               seed_a_d = seed_a_in;
               bip_d    = i_bipolar;
               rem_d    = (i_len == '0) ? FULL_N : i_len;
               ra_d     = seed_a_in;
               rb_d     = seed_b_in;
               count_d  = '0;
               state_d  = S_RUN;
            end else if (state_q == S_DONE) begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            if (rem_q == '0) begin
               state_d = S_DONE;
            end else begin
               count_d = count_q + {{(CW-1){1'b0}}, prod_bit};
               rem_d   = rem_q - 1'b1;
               ra_d    = ra_nxt;
               // When the A generator is about to return to its seed, it has completed one full period.
               if (ra_nxt == seed_a_q) begin
                  rb_d = rb_nxt;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         seed_a_q <= ONE_W;
         bip_q    <= 1'b0;
         rem_q    <= '0;
         ra_q     <= ONE_W;
         rb_q     <= ONE_W;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         seed_a_q <= seed_a_d;
         bip_q    <= bip_d;
         rem_q    <= rem_d;
         ra_q     <= ra_d;
         rb_q     <= rb_d;
         count_q  <= count_d;
      end
   end

   assign o_busy  = (state_q == S_RUN);
   assign o_done  = (state_q == S_DONE);
   assign o_count = count_q;

endmodule
